extmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the shared external memory (13-bit word address, 32-bit data, byte enables, rwb/en/done).
- Shares the memory between the instruction-fetch requester (read-only) and the data requester (read/write) using round-robin arbitration.
- Sequences each access with a minimum hold time, completion on done, and a timeout.
- Returns captured read data with a one-cycle ack to the requester that was granted.

---
 rtl/extmem_arbiter_if.sv | 40 ++++
 rtl/extmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_extmem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/extmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the external memory.
// Handshake: a requester raises *_req with its address/data stable and holds them until
// the matching *_ack pulse (one cycle); the memory ends an access by raising mem_done.
interface extmem_arbiter_if;
   logic        i_req;
   logic [12:0] i_adr;
   logic        i_ack;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_rwb;
   logic [12:0] d_adr;
   logic [31:0] d_wdata;
   logic [3:0]  d_byteen;
   logic        d_ack;
   logic [31:0] d_rdata;

   logic [12:0] mem_adr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [3:0]  mem_byteen;
   logic        mem_rwb;
   logic        mem_en;
   logic        mem_done;

   logic [1:0]  grant;
   logic        err;

   modport slave (
      input  i_req, i_adr, d_req, d_rwb, d_adr, d_wdata, d_byteen, mem_rdata, mem_done,
      output i_ack, i_rdata, d_ack, d_rdata, mem_adr, mem_wdata, mem_byteen, mem_rwb,
             mem_en, grant, err
   );

   modport master (
      output i_req, i_adr, d_req, d_rwb, d_adr, d_wdata, d_byteen, mem_rdata, mem_done,
      input  i_ack, i_rdata, d_ack, d_rdata, mem_adr, mem_wdata, mem_byteen, mem_rwb,
             mem_en, grant, err
   );
endinterface

// File: rtl/extmem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one external memory between the
// instruction-fetch port (read-only) and the data port (read/write).
module extmem_arbiter #(
   parameter int MIN_CYCLES = 2,
   parameter int TIMEOUT    = 64
) (
   input  logic            ph1,
   input  logic            reset,
   extmem_arbiter_if.slave bus,
   output logic [1:0]      state_dbg
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_q, last_d;   // 0 = I served last, 1 = D served last
   logic [12:0]   mem_adr_q, mem_adr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]    mem_byteen_q, mem_byteen_d;
   logic          mem_rwb_q, mem_rwb_d;
   logic          mem_en_q, mem_en_d;
   logic [1:0]    grant_q, grant_d;
   logic          i_ack_q, i_ack_d;
   logic          d_ack_q, d_ack_d;
   logic [31:0]   i_rdata_q, i_rdata_d;
   logic [31:0]   d_rdata_q, d_rdata_d;
   logic          err_q, err_d;
   logic          pick_d;
   logic          complete;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_d       = last_q;
      mem_adr_d    = mem_adr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_byteen_d = mem_byteen_q;
      mem_rwb_d    = mem_rwb_q;
      mem_en_d     = mem_en_q;
      grant_d      = grant_q;
      i_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      err_d        = err_q;
      pick_d       = 1'b0;
      complete     = 1'b0;

      case (state_q)
         IDLE: begin
            // On a tie the port that was not served last wins.
            pick_d = bus.d_req && (!bus.i_req || !last_q);
            if (bus.i_req || bus.d_req) begin
               if (pick_d) begin
                  mem_adr_d    = bus.d_adr;
                  mem_rwb_d    = bus.d_rwb;
                  mem_wdata_d  = bus.d_wdata;
                  mem_byteen_d = bus.d_rwb ? 4'b0000 : bus.d_byteen;
                  grant_d      = 2'b10;
               end else begin
                  mem_adr_d    = bus.i_adr;
                  mem_rwb_d    = 1'b1;
                  mem_byteen_d = 4'b0000;
                  grant_d      = 2'b01;
               end
               mem_en_d = 1'b1;
               cnt_d    = '0;
               state_d  = ACCESS;
            end
         end

         ACCESS: begin
            if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
            complete = ((cnt_q >= CW'(MIN_CYCLES - 1)) && bus.mem_done) ||
                       (cnt_q == CW'(TIMEOUT - 1));
            if (complete) begin
               if (grant_q[0]) begin
                  i_rdata_d = bus.mem_rdata;
                  i_ack_d   = 1'b1;
                  last_d    = 1'b0;
               end else begin
                  if (mem_rwb_q) d_rdata_d = bus.mem_rdata;
                  d_ack_d = 1'b1;
                  last_d  = 1'b1;
               end
               // Completing without mem_done can only mean the timeout fired.
               if (!bus.mem_done) err_d = 1'b1;
               mem_en_d     = 1'b0;
               mem_rwb_d    = 1'b1;
               mem_byteen_d = 4'b0000;
               grant_d      = 2'b00;
               state_d      = DONE;
            end
         end

         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ph1 or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_q       <= 1'b1;
         mem_adr_q    <= '0;
         mem_wdata_q  <= '0;
         mem_byteen_q <= '0;
         mem_rwb_q    <= 1'b1;
         mem_en_q     <= 1'b0;
         grant_q      <= 2'b00;
         i_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
         mem_adr_q    <= mem_adr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_byteen_q <= mem_byteen_d;
         mem_rwb_q    <= mem_rwb_d;
         mem_en_q     <= mem_en_d;
         grant_q      <= grant_d;
         i_ack_q      <= i_ack_d;
         d_ack_q      <= d_ack_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         err_q        <= err_d;
      end
   end

   assign bus.mem_adr    = mem_adr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_byteen = mem_byteen_q;
   assign bus.mem_rwb    = mem_rwb_q;
   assign bus.mem_en     = mem_en_q;
   assign bus.grant      = grant_q;
   assign bus.i_ack      = i_ack_q;
   assign bus.d_ack      = d_ack_q;
   assign bus.i_rdata    = i_rdata_q;
   assign bus.d_rdata    = d_rdata_q;
   assign bus.err        = err_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_extmem_arbiter.sv
// Self-checking bench for extmem_arbiter: directed vectors, arbitration/timeout/reset
// sequences and randomized traffic against a transaction-level memory model.
module tb_extmem_arbiter;
   localparam int MIN_CYCLES = 2;
   localparam int TIMEOUT    = 8;
   localparam int P_I = 0;
   localparam int P_D = 1;

   logic       ph1   = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] state_dbg;

   extmem_arbiter_if bus();

   extmem_arbiter #(.MIN_CYCLES(MIN_CYCLES), .TIMEOUT(TIMEOUT)) dut (
      .ph1(ph1), .reset(reset), .bus(bus), .state_dbg(state_dbg)
   );

   always #5 ph1 = ~ph1;

   int n_cmp  = 0;
   int n_fail = 0;

   // memory seen by the DUT, and the bench's own view of what it should hold
   logic [31:0] ram     [0:8191];
   logic [31:0] ref_mem [0:8191];
   logic        ram_load = 1'b1;

   // expected model state
   int          last_exp = P_D;
   logic        err_exp  = 1'b0;
   logic [31:0] i_rd_exp = '0;
   logic [31:0] d_rd_exp = '0;

   function automatic logic [31:0] init_word(input int a);
      logic [31:0] w;
      w = (32'(a) * 32'h0001_0003) ^ 32'hA5A5_5A5A;
      if (a == 16) w = 32'h8C02_0004;
      if (a == 32) w = 32'h1122_3344;
      return w;
   endfunction

   assign bus.mem_rdata = ram[bus.mem_adr];

   always @(posedge ph1) begin
      if (ram_load) begin
         for (int a = 0; a < 8192; a++) ram[a] <= init_word(a);
      end else if (bus.mem_en && !bus.mem_rwb) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_byteen[b]) ram[bus.mem_adr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_en"},    bus.mem_en, 1'b0);
      check({tag, "_rwb"},   bus.mem_rwb, 1'b1);
      check({tag, "_be"},    bus.mem_byteen, 4'b0000);
      check({tag, "_grant"}, bus.grant, 2'b00);
      check({tag, "_iack"},  bus.i_ack, 1'b0);
      check({tag, "_dack"},  bus.d_ack, 1'b0);
      check({tag, "_err"},   bus.err, err_exp);
   endtask

   task automatic drive_i(input logic [12:0] adr);
      bus.i_req = 1'b1;
      bus.i_adr = adr;
   endtask

   task automatic drive_d(input logic rwb, input logic [12:0] adr,
                          input logic [31:0] wdata, input logic [3:0] be);
      bus.d_req    = 1'b1;
      bus.d_rwb    = rwb;
      bus.d_adr    = adr;
      bus.d_wdata  = wdata;
      bus.d_byteen = be;
   endtask

   function automatic int pick(input logic ir, input logic dr);
      if (ir && dr) return (last_exp == P_D) ? P_I : P_D;
      return ir ? P_I : P_D;
   endfunction

   // Called at the falling edge of an IDLE cycle with requests already driven.
   // done_sel: 0 = mem_done tied 1, 1 = random, 2 = pattern 0,0,1, 3 = held 0.
   task automatic run_access(input int win, input logic rwb, input logic [12:0] adr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input int done_sel, input logic allow_drop);
      logic [1:0]  g;
      logic        rw;
      logic [3:0]  exp_be;
      logic [31:0] exp_rd;
      logic        dk;
      logic        tmo;
      g      = (win == P_I) ? 2'b01 : 2'b10;
      rw     = (win == P_I) ? 1'b1 : rwb;
      exp_be = rw ? 4'b0000 : be;
      exp_rd = ref_mem[adr];
      tmo    = 1'b0;
      dk     = 1'b0;
      @(posedge ph1);
      for (int k = 0; k < TIMEOUT; k++) begin
         @(negedge ph1);
         check("acc_en", bus.mem_en, 1'b1);
         check("acc_grant", bus.grant, g);
         check("acc_adr", bus.mem_adr, adr);
         check("acc_rwb", bus.mem_rwb, rw);
         check("acc_be", bus.mem_byteen, exp_be);
         check("acc_iack", bus.i_ack, 1'b0);
         check("acc_dack", bus.d_ack, 1'b0);
         check("acc_err", bus.err, err_exp);
         if (!rw) check("acc_wdata", bus.mem_wdata, wdata);
         case (done_sel)
            0:       dk = 1'b1;
            1:       dk = 1'($urandom_range(0, 1));
            2:       dk = (k >= 2);
            default: dk = 1'b0;
         endcase
         bus.mem_done = dk;
         if (allow_drop && $urandom_range(0, 3) == 0) begin
            if (win == P_I) begin
               bus.i_req = 1'b0;
               bus.i_adr = 13'($urandom);
            end else begin
               bus.d_req    = 1'b0;
               bus.d_rwb    = 1'($urandom);
               bus.d_adr    = 13'($urandom);
               bus.d_wdata  = $urandom;
               bus.d_byteen = 4'($urandom);
            end
         end
         if ((k >= MIN_CYCLES - 1 && dk) || k == TIMEOUT - 1) begin
            tmo = !dk;
            break;
         end
      end
      @(posedge ph1);
      @(negedge ph1);
      if (tmo) err_exp = 1'b1;
      if (win == P_I) i_rd_exp = exp_rd;
      else if (rw) d_rd_exp = exp_rd;
      check("done_iack", bus.i_ack, (win == P_I));
      check("done_dack", bus.d_ack, (win == P_D));
      check("done_grant", bus.grant, 2'b00);
      check("done_en", bus.mem_en, 1'b0);
      check("done_rwb", bus.mem_rwb, 1'b1);
      check("done_be", bus.mem_byteen, 4'b0000);
      check("done_err", bus.err, err_exp);
      check("done_irdata", bus.i_rdata, i_rd_exp);
      check("done_drdata", bus.d_rdata, d_rd_exp);
      if (!rw)
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[adr][b*8 +: 8] = wdata[b*8 +: 8];
      last_exp = win;
      if (win == P_I) bus.i_req = 1'b0;
      else bus.d_req = 1'b0;
      bus.mem_done = 1'b1;
      @(posedge ph1);
      @(negedge ph1);
      check_idle("idle");
   endtask

   typedef struct {
      int          port;
      logic        rwb;
      logic [12:0] adr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          win;
      logic        rwb;
      logic [12:0] adr;
      logic [31:0] wd;
      logic [3:0]  be;

      tbl[0] = '{P_I, 1'b1, 13'h010, 32'h0,         4'b0000, 32'h8C02_0004};
      tbl[1] = '{P_D, 1'b0, 13'h020, 32'hAABB_CCDD, 4'b0010, 32'h0};
      tbl[2] = '{P_D, 1'b1, 13'h020, 32'h0,         4'b0000, 32'h1122_CC44};
      tbl[3] = '{P_D, 1'b0, 13'h030, 32'hDEAD_BEEF, 4'b1111, 32'h0};
      tbl[4] = '{P_I, 1'b1, 13'h030, 32'h0,         4'b0000, 32'hDEAD_BEEF};
      tbl[5] = '{P_D, 1'b0, 13'h020, 32'h5566_7788, 4'b1001, 32'h0};
      tbl[6] = '{P_D, 1'b1, 13'h020, 32'h0,         4'b0000, 32'h5522_CC88};
      tbl[7] = '{P_D, 1'b0, 13'h030, 32'h1234_5678, 4'b0000, 32'h0};
      tbl[8] = '{P_D, 1'b1, 13'h030, 32'h0,         4'b0000, 32'hDEAD_BEEF};

      for (int a = 0; a < 8192; a++) ref_mem[a] = init_word(a);
      bus.i_req = 1'b0; bus.i_adr = '0;
      bus.d_req = 1'b0; bus.d_rwb = 1'b1; bus.d_adr = '0; bus.d_wdata = '0; bus.d_byteen = '0;
      bus.mem_done = 1'b1;

      // reset values, applied asynchronously
      #1 reset = 1'b1;
      #1;
      check("rst_adr", bus.mem_adr, 13'h0);
      check("rst_wdata", bus.mem_wdata, 32'h0);
      check("rst_irdata", bus.i_rdata, 32'h0);
      check("rst_drdata", bus.d_rdata, 32'h0);
      check_idle("rst");
      @(negedge ph1);
      ram_load = 1'b0;
      @(negedge ph1);
      reset = 1'b0;

      // both requesters held: grants alternate I, D, I, D starting with I
      drive_i(13'h100);
      drive_d(1'b1, 13'h101, 32'h0, 4'b0000);
      for (int n = 0; n < 4; n++) begin
         win = (n % 2 == 0) ? P_I : P_D;
         if (win == P_I) run_access(P_I, 1'b1, 13'h100, 32'h0, 4'b0000, 0, 1'b0);
         else run_access(P_D, 1'b1, 13'h101, 32'h0, 4'b0000, 0, 1'b0);
         if (win == P_I) drive_i(13'h100);
         else drive_d(1'b1, 13'h101, 32'h0, 4'b0000);
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      @(negedge ph1);

      // directed single accesses, mem_done tied 1
      for (int v = 0; v < 9; v++) begin
         if (tbl[v].port == P_I) drive_i(tbl[v].adr);
         else drive_d(tbl[v].rwb, tbl[v].adr, tbl[v].wdata, tbl[v].be);
         run_access(tbl[v].port, tbl[v].rwb, tbl[v].adr, tbl[v].wdata, tbl[v].be, 0, 1'b0);
         if (tbl[v].port == P_I) check("tbl_irdata", bus.i_rdata, tbl[v].exp_rd);
         else if (tbl[v].rwb) check("tbl_drdata", bus.d_rdata, tbl[v].exp_rd);
      end

      // mem_done 0,0,1: completes on the third ACCESS cycle without error
      drive_d(1'b1, 13'h020, 32'h0, 4'b0000);
      run_access(P_D, 1'b1, 13'h020, 32'h0, 4'b0000, 2, 1'b0);
      check("pat_drdata", bus.d_rdata, 32'h5522_CC88);
      check("pat_err", bus.err, 1'b0);

      // randomized traffic
      for (int r = 0; r < 60; r++) begin
         if (!bus.i_req && $urandom_range(0, 1) == 1) drive_i(13'($urandom_range(0, 63)));
         if (!bus.d_req && $urandom_range(0, 1) == 1)
            drive_d(1'($urandom), 13'($urandom_range(0, 63)), $urandom, 4'($urandom));
         if (!bus.i_req && !bus.d_req)
            drive_d(1'($urandom), 13'($urandom_range(0, 63)), $urandom, 4'($urandom));
         win = pick(bus.i_req, bus.d_req);
         if (win == P_I) begin
            rwb = 1'b1; adr = bus.i_adr; wd = '0; be = '0;
         end else begin
            rwb = bus.d_rwb; adr = bus.d_adr; wd = bus.d_wdata; be = bus.d_byteen;
         end
         run_access(win, rwb, adr, wd, be, int'($urandom_range(0, 1)), 1'b1);
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      @(negedge ph1);

      // timeout with mem_done held low sets the sticky error
      drive_d(1'b1, 13'h005, 32'h0, 4'b0000);
      run_access(P_D, 1'b1, 13'h005, 32'h0, 4'b0000, 3, 1'b0);
      check("tmo_err", bus.err, 1'b1);
      drive_i(13'h010);
      run_access(P_I, 1'b1, 13'h010, 32'h0, 4'b0000, 0, 1'b0);
      check("tmo_err_sticky", bus.err, 1'b1);

      // reset in the middle of a data write, then the held request is serviced
      drive_d(1'b0, 13'h040, 32'hCAFE_F00D, 4'b1111);
      @(posedge ph1);
      @(negedge ph1);
      check("mid_rwb_low", bus.mem_rwb, 1'b0);
      @(posedge ph1);
      #2 reset = 1'b1;
      #1;
      err_exp  = 1'b0;
      last_exp = P_D;
      i_rd_exp = '0;
      d_rd_exp = '0;
      check_idle("midrst");
      check("midrst_drdata", bus.d_rdata, 32'h0);
      @(negedge ph1);
      reset = 1'b0;
      run_access(P_D, 1'b0, 13'h040, 32'hCAFE_F00D, 4'b1111, 0, 1'b0);
      drive_d(1'b1, 13'h040, 32'h0, 4'b0000);
      run_access(P_D, 1'b1, 13'h040, 32'h0, 4'b0000, 0, 1'b0);
      check("post_rst_rd", bus.d_rdata, 32'hCAFE_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
